// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: central stall arbiter for the 5-stage pipeline.
// Resolves ID/EX/MEM stall requests into the per-stage stall vector,
// keeps ID fed from a hold buffer while IF/ID is frozen, counts stalled
// cycles and watches for an EX unit that stays busy too long.
module pipe_stall_ctrl #(
    parameter int STALL_W    = 6,
    parameter int CNT_W      = 16,
    parameter int WDOG_LIMIT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_for_id,
    input  logic               stallreq_for_ex,
    input  logic               stallreq_for_mem,
    input  logic [31:0]        inst_sram_rdata,
    output logic [STALL_W-1:0] stall,
    output logic [31:0]        id_inst,
    output logic               hold_valid,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic               wdog_err
);

    // Stall patterns: bit0=PC ... bit5=WB, 1 freezes the stage.
    localparam logic [STALL_W-1:0] STALL_MEM  = STALL_W'(6'b011111);
    localparam logic [STALL_W-1:0] STALL_EX   = STALL_W'(6'b001111);
    localparam logic [STALL_W-1:0] STALL_ID   = STALL_W'(6'b000111);
    localparam logic [STALL_W-1:0] STALL_NONE = '0;

    localparam int BW = $clog2(WDOG_LIMIT) + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_USE = 2'd1,
        EX_BUSY  = 2'd2,
        MEM_WAIT = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            id_eff;
    logic [31:0]     hold_inst;
    logic [BW-1:0]   busy_cnt;

    // Stall vector: deepest requesting stage wins; the ID request is ignored
    // for the one cycle after a load-use bubble since forwarding covers it.
    always_comb begin
        id_eff = stallreq_for_id && (state != LOAD_USE);
        stall  = STALL_NONE;
        if (!rst)                  stall = STALL_NONE;
        else if (stallreq_for_mem) stall = STALL_MEM;
        else if (stallreq_for_ex)  stall = STALL_EX;
        else if (id_eff)           stall = STALL_ID;
    end

    // Next-state selection; EX_BUSY and LOAD_USE never go to LOAD_USE.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            EX_BUSY, LOAD_USE: begin
                if (stallreq_for_mem)     state_nxt = MEM_WAIT;
                else if (stallreq_for_ex) state_nxt = EX_BUSY;
                else                      state_nxt = IDLE;
            end
            default: begin
                if (stallreq_for_mem)     state_nxt = MEM_WAIT;
                else if (stallreq_for_ex) state_nxt = EX_BUSY;
                else if (stallreq_for_id) state_nxt = LOAD_USE;
                else                      state_nxt = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Hold buffer: capture once at the start of an ID freeze, drop when it ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_valid <= 1'b0;
            hold_inst  <= '0;
        end else if (stall[2] && !hold_valid) begin
            hold_valid <= 1'b1;
            hold_inst  <= inst_sram_rdata;
        end else if (!stall[2]) begin
            hold_valid <= 1'b0;
        end
    end

    assign id_inst = hold_valid ? hold_inst : inst_sram_rdata;

    // Saturating count of cycles in which any stage is stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cycles <= '0;
        else if ((stall != STALL_NONE) && (stall_cycles != {CNT_W{1'b1}}))
            stall_cycles <= stall_cycles + 1'b1;
    end

    // EX watchdog: busy_cnt holds the length of the current EX_BUSY run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_cnt <= '0;
            wdog_err <= 1'b0;
        end else begin
            if (state_nxt != EX_BUSY)
                busy_cnt <= '0;
            else if (busy_cnt != BW'(WDOG_LIMIT))
                busy_cnt <= busy_cnt + 1'b1;
            if ((busy_cnt == BW'(WDOG_LIMIT - 1)) && stallreq_for_ex)
                wdog_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios plus random traffic, checked
// every cycle against a history-based model of the stall rules. Two DUTs
// share inputs to cover both counter widths.
module tb_pipe_stall_ctrl;
    localparam int LIM = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rid = 1'b0, rex = 1'b0, rmem = 1'b0;
    logic [31:0] rdata = '0;

    logic [5:0]  a_stall, b_stall;
    logic [31:0] a_inst, b_inst;
    logic        a_hv, b_hv, a_wd, b_wd;
    logic [15:0] a_cnt;
    logic [3:0]  b_cnt;

    int tests = 0;
    int fails = 0;
    int burst = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.STALL_W(6), .CNT_W(16), .WDOG_LIMIT(LIM)) dut_a (
        .clk(clk), .rst(rst), .stallreq_for_id(rid), .stallreq_for_ex(rex),
        .stallreq_for_mem(rmem), .inst_sram_rdata(rdata), .stall(a_stall),
        .id_inst(a_inst), .hold_valid(a_hv), .stall_cycles(a_cnt), .wdog_err(a_wd));

    pipe_stall_ctrl #(.STALL_W(6), .CNT_W(4), .WDOG_LIMIT(LIM)) dut_b (
        .clk(clk), .rst(rst), .stallreq_for_id(rid), .stallreq_for_ex(rex),
        .stallreq_for_mem(rmem), .inst_sram_rdata(rdata), .stall(b_stall),
        .id_inst(b_inst), .hold_valid(b_hv), .stall_cycles(b_cnt), .wdog_err(b_wd));

    // Model: the ID request is masked exactly when the previous cycle was a
    // pure load-use bubble that did not follow an EX stall.
    logic [5:0]  s1 = '0, s2 = '0;
    int          run = 0;
    int          mcnt = 0;
    logic        mhv = 1'b0, mwd = 1'b0;
    logic [31:0] mhi = '0;

    wire       masked = (s1 == 6'h07) && (s2 != 6'h0F);
    wire [5:0] es = !rst ? 6'h00 : rmem ? 6'h1F : rex ? 6'h0F :
                    (rid && !masked) ? 6'h07 : 6'h00;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0; s2 <= '0; run <= 0; mcnt <= 0;
            mhv <= 1'b0; mwd <= 1'b0; mhi <= '0;
        end else begin
            s2   <= s1;
            s1   <= es;
            run  <= (es == 6'h0F) ? run + 1 : 0;
            if (run >= LIM - 1 && rex) mwd <= 1'b1;
            if (es[2] && !mhv) mhi <= rdata;
            mhv  <= es[2];
            mcnt <= mcnt + ((es != 6'h00) ? 1 : 0);
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("stall_a", 32'(a_stall), 32'(es));
        chk("stall_b", 32'(b_stall), 32'(es));
        chk("inst_a", a_inst, mhv ? mhi : rdata);
        chk("inst_b", b_inst, mhv ? mhi : rdata);
        chk("hv_a", 32'(a_hv), 32'(mhv));
        chk("hv_b", 32'(b_hv), 32'(mhv));
        chk("cnt_a", 32'(a_cnt), (mcnt > 65535) ? 32'd65535 : 32'(mcnt));
        chk("cnt_b", 32'(b_cnt), (mcnt > 15) ? 32'd15 : 32'(mcnt));
        chk("wd_a", 32'(a_wd), 32'(mwd));
        chk("wd_b", 32'(b_wd), 32'(mwd));
    endtask

    task automatic samp();
        @(negedge clk);
        compare_all();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rid = 0; rex = 0; rmem = 0;
        repeat (n) begin samp(); adv(); end
    endtask

    initial begin
        // Reset with every request high.
        rid = 1; rex = 1; rmem = 1;
        repeat (3) begin
            samp();
            chk("rst_stall", 32'(a_stall), 0);
            chk("rst_hv", 32'(a_hv), 0);
            chk("rst_cnt", 32'(a_cnt), 0);
            chk("rst_wd", 32'(a_wd), 0);
            adv();
        end
        rst = 1;
        idle(1);

        // Load-use bubble with hold capture.
        rdata = 32'h8C220004; rid = 1;
        samp(); chk("lu_c0", 32'(a_stall), 32'h07); adv();
        rdata = 32'h0;
        samp();
        chk("lu_c1", 32'(a_stall), 32'h00);
        chk("lu_inst", a_inst, 32'h8C220004);
        chk("lu_hv", 32'(a_hv), 1);
        adv();
        rid = 0;
        samp(); chk("lu_rel_hv", 32'(a_hv), 0); adv();
        idle(2);

        // EX busy with MEM preempting for two cycles.
        for (int i = 0; i < 10; i++) begin
            rex = 1; rmem = (i == 4 || i == 5); rdata = $urandom;
            samp(); chk("ex_mem", 32'(a_stall), (i == 4 || i == 5) ? 32'h1F : 32'h0F); adv();
        end
        rex = 0; rmem = 0;
        samp(); chk("ex_done", 32'(a_stall), 0); chk("ex_cnt", 32'(a_cnt), 11); adv();
        idle(1);

        // Simultaneous requests peeled off deepest-first.
        rid = 1; rex = 1; rmem = 1;
        samp(); chk("all3", 32'(a_stall), 32'h1F); adv();
        rmem = 0;
        samp(); chk("ex_id", 32'(a_stall), 32'h0F); adv();
        rex = 0;
        samp(); chk("id_only", 32'(a_stall), 32'h07); adv();
        idle(2);

        // Watchdog on a 64-cycle EX run.
        rex = 1;
        for (int i = 0; i < 64; i++) begin
            samp();
            if (i == 63) chk("wd_pre", 32'(a_wd), 0);
            adv();
        end
        rex = 0;
        samp(); chk("wd_set", 32'(a_wd), 1); chk("cnt78", 32'(a_cnt), 78); adv();
        idle(3);
        samp(); chk("wd_sticky", 32'(a_wd), 1); adv();

        // Counter saturation on a fresh reset.
        rst = 0; samp(); adv(); rst = 1;
        rmem = 1;
        repeat (20) begin samp(); adv(); end
        rmem = 0;
        samp(); chk("sat4", 32'(b_cnt), 15); chk("cnt20", 32'(a_cnt), 20); adv();

        // Reset in the middle of a stall.
        rmem = 1; rid = 1; rdata = 32'hDEADBEEF;
        samp(); adv();
        rst = 0;
        samp(); chk("mid_rst_stall", 32'(a_stall), 0); chk("mid_rst_hv", 32'(a_hv), 0); adv();
        rst = 1;
        idle(2);

        // Random traffic with occasional long EX bursts and resets.
        for (int i = 0; i < 4000; i++) begin
            if (burst == 0 && ($urandom % 400) == 0) burst = 70;
            rst  = (($urandom % 300) != 0);
            rmem = (($urandom % 6) == 0);
            if (burst > 0) begin rex = 1; burst--; end
            else rex = (($urandom % 4) == 0);
            rid   = (($urandom % 3) == 0);
            rdata = $urandom;
            samp();
            adv();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
